// File: rtl/aes128_iter_core_if.sv
// Handshake bundle between the bus side and the iterative AES-128 core.
// AES_KEY_REUSE_EN adds the key_load select for the cached-key path.
interface aes128_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
    logic [3:0]   round_idx;
`ifdef AES_KEY_REUSE_EN
    logic         key_load;
`endif

    modport master (
`ifdef AES_KEY_REUSE_EN
        output key_load,
`endif
        output in_valid, key_in, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy, round_idx
    );

    modport slave (
`ifdef AES_KEY_REUSE_EN
        input  key_load,
`endif
        input  in_valid, key_in, data_in, out_ready,
        output in_ready, out_valid, data_out, busy, round_idx
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one shared round datapath, on-the-fly key expansion.
// Define AES_KEY_REUSE_EN to add key_load and a cached cipher key.
module aes128_iter_core #(
    parameter int NR     = 10,
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst,
    aes128_iter_core_if.slave  aes_io
);

    localparam logic [3:0] NR_L   = 4'(NR);
    localparam logic [3:0] STEP_L = 4'(UNROLL);

    // Byte x lives at bits {~x, 3'b111} -: 8, so row 0 sits at the MSB end.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (NR < 1 || NR > 10 || (UNROLL != 1 && UNROLL != 2) || (NR % UNROLL) != 0) begin : gen_param_check
        $error("aes128_iter_core: illegal NR=%0d / UNROLL=%0d combination", NR, UNROLL);
    end

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsmState_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes fused with ShiftRows: output (row r, col c) takes input column (c + r) mod 4.
    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] expandKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    fsmState_t    fsmState_q, fsmState_d;
    logic [127:0] aesState_q, aesState_d;
    logic [127:0] roundKey_q, roundKey_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   roundIdx_q, roundIdx_d;
    logic [127:0] dataOut_q, dataOut_d;
    logic [127:0] effKey;

    logic [127:0] stepState, stepKey;
    logic [7:0]   stepRcon;

    logic [127:0] key1, sub1, state1;
    logic [7:0]   rcon1;
    logic         final1;

    assign key1   = expandKey(roundKey_q, rcon_q);
    assign sub1   = subShift(aesState_q);
    assign final1 = (roundIdx_q + 4'd1) == NR_L;
    assign state1 = (final1 ? sub1 : mixColumns(sub1)) ^ key1;
    assign rcon1  = xtime(rcon_q);

    // The second stage chains off the first so two rounds retire per edge.
    if (UNROLL == 2) begin : gen_unroll2
        logic [127:0] key2, sub2;
        logic         final2;
        assign key2      = expandKey(key1, rcon1);
        assign sub2      = subShift(state1);
        assign final2    = (roundIdx_q + 4'd2) == NR_L;
        assign stepKey   = key2;
        assign stepState = (final2 ? sub2 : mixColumns(sub2)) ^ key2;
        assign stepRcon  = xtime(rcon1);
    end else begin : gen_unroll1
        assign stepKey   = key1;
        assign stepState = state1;
        assign stepRcon  = rcon1;
    end

`ifdef AES_KEY_REUSE_EN
    logic [127:0] keyCache_q, keyCache_d;
    assign effKey = aes_io.key_load ? aes_io.key_in : keyCache_q;
`else
    assign effKey = aes_io.key_in;
`endif

    always_comb begin
        fsmState_d = fsmState_q;
        aesState_d = aesState_q;
        roundKey_d = roundKey_q;
        rcon_d     = rcon_q;
        roundIdx_d = roundIdx_q;
        dataOut_d  = dataOut_q;
`ifdef AES_KEY_REUSE_EN
        keyCache_d = keyCache_q;
`endif
        case (fsmState_q)
            IDLE: begin
                if (aes_io.in_valid) begin
                    aesState_d = aes_io.data_in ^ effKey;
                    roundKey_d = effKey;
                    rcon_d     = 8'h01;
                    roundIdx_d = 4'd0;
                    fsmState_d = ROUND;
`ifdef AES_KEY_REUSE_EN
                    if (aes_io.key_load) begin
                        keyCache_d = aes_io.key_in;
                    end
`endif
                end
            end
            ROUND: begin
                aesState_d = stepState;
                roundKey_d = stepKey;
                rcon_d     = stepRcon;
                roundIdx_d = roundIdx_q + STEP_L;
                if ((roundIdx_q + STEP_L) == NR_L) begin
                    dataOut_d  = stepState;
                    fsmState_d = DONE;
                end
            end
            DONE: begin
                if (aes_io.out_ready) begin
                    fsmState_d = IDLE;
                end
            end
            default: fsmState_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsmState_q <= IDLE;
            aesState_q <= '0;
            roundKey_q <= '0;
            rcon_q     <= '0;
            roundIdx_q <= '0;
            dataOut_q  <= '0;
`ifdef AES_KEY_REUSE_EN
            keyCache_q <= '0;
`endif
        end else begin
            fsmState_q <= fsmState_d;
            aesState_q <= aesState_d;
            roundKey_q <= roundKey_d;
            rcon_q     <= rcon_d;
            roundIdx_q <= roundIdx_d;
            dataOut_q  <= dataOut_d;
`ifdef AES_KEY_REUSE_EN
            keyCache_q <= keyCache_d;
`endif
        end
    end

    assign aes_io.in_ready  = (fsmState_q == IDLE);
    assign aes_io.out_valid = (fsmState_q == DONE);
    assign aes_io.busy      = (fsmState_q != IDLE);
    assign aes_io.data_out  = dataOut_q;
    assign aes_io.round_idx = roundIdx_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core using the FIPS-197 App. B and C.1 vectors,
// on a default core and an UNROLL=2 core sharing clock and reset.
module tb_aes128_iter_core;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    aes128_iter_core_if ifA ();
    aes128_iter_core_if ifB ();

    aes128_iter_core #(.NR(10), .UNROLL(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .aes_io (ifA)
    );

    aes128_iter_core #(.NR(10), .UNROLL(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .aes_io (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one block on the default core; lat counts edges from acceptance to out_valid.
    task automatic run_block_a(input logic [127:0] key, input logic [127:0] data,
                               output logic [127:0] res, output int lat, output bit timedOut);
        ifA.key_in    = key;
        ifA.data_in   = data;
        ifA.out_ready = 1'b1;
        ifA.in_valid  = 1'b1;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        lat      = 0;
        timedOut = 1'b1;
        while (lat < 30) begin
            if (ifA.out_valid === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
        res = ifA.data_out;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ifA.in_ready !== 1'b1 || ifA.out_valid !== 1'b0 || ifA.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     ifA.in_ready, ifA.out_valid, ifA.busy);
        end
        checks++;
        if (ifA.round_idx !== 4'd0 || ifA.data_out !== 128'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: round_idx=%0d data_out=%h, required 0 and 0",
                     ifA.round_idx, ifA.data_out);
        end
        checks++;
        if (ifB.in_ready !== 1'b1 || ifB.out_valid !== 1'b0 || ifB.data_out !== 128'd0) begin
            failures++;
            $display("[TB] FAIL reset_unroll2: in_ready=%b out_valid=%b data_out=%h, required 1 0 0",
                     ifB.in_ready, ifB.out_valid, ifB.data_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips_b();
        ifA.key_in    = B_KEY;
        ifA.data_in   = B_PT;
        ifA.out_ready = 1'b1;
        ifA.in_valid  = 1'b1;
        checks++;
        if (ifA.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL appb_ready: in_ready=%b, required 1", ifA.in_ready);
        end
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            ifA.in_valid = 1'b0;
            checks++;
            if (ifA.round_idx !== 4'(j) || ifA.out_valid !== (j == 10) || ifA.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL appb_step%0d: round_idx=%0d out_valid=%b busy=%b, required %0d %b 1",
                         j, ifA.round_idx, ifA.out_valid, ifA.busy, j, (j == 10));
            end
        end
        checks++;
        if (ifA.data_out !== B_CT) begin
            failures++;
            $display("[TB] FAIL appb_data: got %h, required %h", ifA.data_out, B_CT);
        end
        @(negedge clk);
        checks++;
        if (ifA.out_valid !== 1'b0 || ifA.in_ready !== 1'b1 || ifA.busy !== 1'b0 || ifA.data_out !== B_CT) begin
            failures++;
            $display("[TB] FAIL appb_after: out_valid=%b in_ready=%b busy=%b data_out=%h, required 0 1 0 %h",
                     ifA.out_valid, ifA.in_ready, ifA.busy, ifA.data_out, B_CT);
        end
    endtask

    task automatic test_unroll2();
        ifB.key_in    = C_KEY;
        ifB.data_in   = C_PT;
        ifB.out_ready = 1'b1;
        ifB.in_valid  = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            ifB.in_valid = 1'b0;
            checks++;
            if (ifB.round_idx !== 4'(2*j) || ifB.out_valid !== (j == 5)) begin
                failures++;
                $display("[TB] FAIL c1_u2_step%0d: round_idx=%0d out_valid=%b, required %0d %b",
                         j, ifB.round_idx, ifB.out_valid, 2*j, (j == 5));
            end
        end
        checks++;
        if (ifB.data_out !== C_CT) begin
            failures++;
            $display("[TB] FAIL c1_u2_data: got %h, required %h", ifB.data_out, C_CT);
        end
        @(negedge clk);
        checks++;
        if (ifB.out_valid !== 1'b0 || ifB.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL c1_u2_after: out_valid=%b in_ready=%b, required 0 1",
                     ifB.out_valid, ifB.in_ready);
        end
    endtask

    task automatic test_backpressure();
        ifA.key_in    = B_KEY;
        ifA.data_in   = B_PT;
        ifA.out_ready = 1'b0;
        ifA.in_valid  = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            ifA.in_valid = 1'b0;
        end
        checks++;
        if (ifA.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_complete: out_valid=%b, required 1", ifA.out_valid);
        end
        for (int k = 0; k < 20; k++) begin
            ifA.in_valid = 1'b1;
            ifA.key_in   = C_KEY;
            ifA.data_in  = C_PT;
            @(negedge clk);
            checks++;
            if (ifA.out_valid !== 1'b1 || ifA.in_ready !== 1'b0 || ifA.data_out !== B_CT || ifA.round_idx !== 4'd10) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d: out_valid=%b in_ready=%b data_out=%h round_idx=%0d, required 1 0 %h 10",
                         k, ifA.out_valid, ifA.in_ready, ifA.data_out, ifA.round_idx, B_CT);
            end
        end
        ifA.in_valid  = 1'b0;
        ifA.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifA.out_valid !== 1'b0 || ifA.in_ready !== 1'b1 || ifA.data_out !== B_CT) begin
            failures++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b data_out=%h, required 0 1 %h",
                     ifA.out_valid, ifA.in_ready, ifA.data_out, B_CT);
        end
        @(negedge clk);
        checks++;
        if (ifA.out_valid !== 1'b0 || ifA.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_single: out_valid=%b busy=%b, required 0 0", ifA.out_valid, ifA.busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] res;
        int           lat;
        bit           timedOut;
        int           waited;
        ifA.key_in    = B_KEY;
        ifA.data_in   = B_PT;
        ifA.out_ready = 1'b1;
        ifA.in_valid  = 1'b1;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        waited = 0;
        while (ifA.round_idx !== 4'd4 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ifA.round_idx !== 4'd4) begin
            failures++;
            $display("[TB] FAIL abort_reach4: round_idx=%0d, required 4", ifA.round_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifA.busy !== 1'b0 || ifA.in_ready !== 1'b1 || ifA.round_idx !== 4'd0 || ifA.data_out !== 128'd0) begin
            failures++;
            $display("[TB] FAIL abort_async: busy=%b in_ready=%b round_idx=%0d data_out=%h, required 0 1 0 0",
                     ifA.busy, ifA.in_ready, ifA.round_idx, ifA.data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (ifA.out_valid !== 1'b0 || ifA.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_quiet%0d: out_valid=%b busy=%b, required 0 0", k, ifA.out_valid, ifA.busy);
            end
        end
        run_block_a(B_KEY, B_PT, res, lat, timedOut);
        checks++;
        if (timedOut !== 1'b0 || lat !== 10 || res !== B_CT) begin
            failures++;
            $display("[TB] FAIL abort_rerun: timeout=%b latency=%0d data=%h, required 0 10 %h",
                     timedOut, lat, res, B_CT);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] keys [2];
        logic [127:0] pts  [2];
        logic [127:0] cts  [2];
        int           doneCyc [2];
        int           inIdx;
        int           outIdx;
        keys[0] = B_KEY; pts[0] = B_PT; cts[0] = B_CT;
        keys[1] = C_KEY; pts[1] = C_PT; cts[1] = C_CT;
        doneCyc[0] = 0;
        doneCyc[1] = 0;
        inIdx  = 0;
        outIdx = 0;
        ifA.out_ready = 1'b1;
        for (int k = 0; k < 40 && outIdx < 2; k++) begin
            if (ifA.out_valid === 1'b1) begin
                checks++;
                if (ifA.data_out !== cts[outIdx]) begin
                    failures++;
                    $display("[TB] FAIL b2b_data%0d: got %h, required %h", outIdx, ifA.data_out, cts[outIdx]);
                end
                doneCyc[outIdx] = k;
                outIdx++;
            end
            if (ifA.in_ready === 1'b1) begin
                if (inIdx < 2) begin
                    ifA.key_in   = keys[inIdx];
                    ifA.data_in  = pts[inIdx];
                    ifA.in_valid = 1'b1;
                    inIdx++;
                end else begin
                    ifA.in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        ifA.in_valid = 1'b0;
        checks++;
        if (outIdx !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_count: completed %0d blocks, required 2", outIdx);
        end
        checks++;
        if (doneCyc[1] - doneCyc[0] !== 12) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: %0d cycles apart, required 12", doneCyc[1] - doneCyc[0]);
        end
        @(negedge clk);
        checks++;
        if (ifA.busy !== 1'b0 || ifA.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_idle: busy=%b in_ready=%b, required 0 1", ifA.busy, ifA.in_ready);
        end
    endtask

`ifdef AES_KEY_REUSE_EN
    task automatic test_key_reuse();
        logic [127:0] res;
        int           lat;
        bit           timedOut;
        ifA.key_load = 1'b1;
        run_block_a(B_KEY, B_PT, res, lat, timedOut);
        checks++;
        if (timedOut !== 1'b0 || res !== B_CT) begin
            failures++;
            $display("[TB] FAIL reuse_load: timeout=%b data=%h, required 0 %h", timedOut, res, B_CT);
        end
        ifA.key_load = 1'b0;
        run_block_a(128'd0, B_PT, res, lat, timedOut);
        checks++;
        if (timedOut !== 1'b0 || res !== B_CT) begin
            failures++;
            $display("[TB] FAIL reuse_cached: timeout=%b data=%h, required 0 %h", timedOut, res, B_CT);
        end
        ifA.key_load = 1'b1;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ifA.in_valid  = 1'b0;
        ifA.out_ready = 1'b0;
        ifA.key_in    = '0;
        ifA.data_in   = '0;
        ifB.in_valid  = 1'b0;
        ifB.out_ready = 1'b0;
        ifB.key_in    = '0;
        ifB.data_in   = '0;
`ifdef AES_KEY_REUSE_EN
        ifA.key_load  = 1'b1;
        ifB.key_load  = 1'b1;
`endif
        $display("[TB] starting aes128_iter_core bench");
        test_reset();
        test_fips_b();
        test_unroll2();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
`ifdef AES_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
